// File: rtl/ac_motor_pwm_bridge_if.sv
// Generator-side inputs and gate-driver outputs of the H-bridge PWM stage.
interface ac_motor_pwm_bridge_if #(
  parameter int WIDTH = 25
);
  logic signed [WIDTH-1:0] triangle;
  logic signed [WIDTH-1:0] level;
  logic                    cw;
  logic                    ccw;
  logic                    lock;
  logic                    hi_a;
  logic                    lo_a;
  logic                    hi_b;
  logic                    lo_b;
  logic                    busy;
  logic                    fault;

  modport slave (
    input  triangle, level, cw, ccw, lock,
    output hi_a, lo_a, hi_b, lo_b, busy, fault
  );

  modport master (
    output triangle, level, cw, ccw, lock,
    input  hi_a, lo_a, hi_b, lo_b, busy, fault
  );
endinterface

// File: rtl/ac_motor_pwm_bridge.sv
// Triangle-carrier comparator driving a single-phase H-bridge with per-leg dead time.
// Start is gated on a rising carrier zero crossing; any loss of direction drops all gates.

module ac_motor_pwm_leg #(
  parameter int DEAD_TIME = 50,
  parameter int DEAD_W    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic want,
  output logic hi,
  output logic lo
);
  localparam logic [DEAD_W-1:0] DT_MAX = DEAD_W'(DEAD_TIME);

  logic [DEAD_W-1:0] dt;
  logic [DEAD_W-1:0] dt_nxt;
  logic              prev;

  assign dt_nxt = (dt == DT_MAX) ? dt : dt + 1'b1;

  // Outside RUN the previous-desired tracks the input so RUN entry never counts as a toggle.
  always_ff @(posedge clk) begin
    if (reset || !en || (want != prev)) begin
      dt   <= '0;
      hi   <= 1'b0;
      lo   <= 1'b0;
      prev <= want;
    end else begin
      dt <= dt_nxt;
      hi <= want  && (dt_nxt == DT_MAX);
      lo <= !want && (dt_nxt == DT_MAX);
    end
  end
endmodule

module ac_motor_pwm_bridge #(
  parameter int WIDTH     = 25,
  parameter int DEAD_TIME = 50,
  parameter int DEAD_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  ac_motor_pwm_bridge_if.slave  bus
);
  localparam int NUM_LEGS = 2;

  typedef enum logic [1:0] {OFF, ARM, RUN} state_t;

  state_t                  state;
  logic                    dir_r;
  logic signed [WIDTH-1:0] tri_prev;
  logic                    busy_r;
  logic                    fault_r;

  logic                    dir_ok;
  logic                    hold;
  logic                    crossing;
  logic                    cmp;
  logic                    run_keep;
  logic [NUM_LEGS-1:0]     want;
  logic [NUM_LEGS-1:0]     hi;
  logic [NUM_LEGS-1:0]     lo;

  assign dir_ok   = bus.lock & (bus.cw ^ bus.ccw);
  assign hold     = dir_ok & (bus.ccw == dir_r);
  assign crossing = tri_prev[WIDTH-1] & ~bus.triangle[WIDTH-1];
  assign cmp      = $signed(bus.level) > $signed(bus.triangle);
  assign run_keep = (state == RUN) & hold;
  assign want[0]  = cmp ^ dir_r;
  assign want[1]  = ~want[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= OFF;
      dir_r    <= 1'b0;
      tri_prev <= '0;
      busy_r   <= 1'b0;
      fault_r  <= 1'b0;
    end else begin
      tri_prev <= bus.triangle;
      fault_r  <= bus.cw & bus.ccw;
      case (state)
        OFF: if (dir_ok) begin
          state <= ARM;
          dir_r <= bus.ccw;
        end
        // Losing direction beats a coincident zero crossing.
        ARM: if (!hold) begin
          state <= OFF;
        end else if (crossing) begin
          state  <= RUN;
          busy_r <= 1'b1;
        end
        RUN: if (!hold) begin
          state  <= OFF;
          busy_r <= 1'b0;
        end
        default: begin
          state  <= OFF;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_LEGS; g++) begin : g_leg
    ac_motor_pwm_leg #(
      .DEAD_TIME (DEAD_TIME),
      .DEAD_W    (DEAD_W)
    ) u_leg (
      .clk   (clk),
      .reset (reset),
      .en    (run_keep),
      .want  (want[g]),
      .hi    (hi[g]),
      .lo    (lo[g])
    );
  end

  assign bus.hi_a  = hi[0];
  assign bus.lo_a  = lo[0];
  assign bus.hi_b  = hi[1];
  assign bus.lo_b  = lo[1];
  assign bus.busy  = busy_r;
  assign bus.fault = fault_r;
endmodule

// File: tb/tb_ac_motor_pwm_bridge.sv
// Directed bench for the H-bridge PWM stage; outputs checked as {hi_a,lo_a,hi_b,lo_b,busy,fault}.
module tb_ac_motor_pwm_bridge;
  localparam int WIDTH = 25;

  logic clk = 1'b0;
  logic reset;
  int   total  = 0;
  int   passed = 0;

  ac_motor_pwm_bridge_if #(.WIDTH(WIDTH)) bus ();

  ac_motor_pwm_bridge #(
    .WIDTH     (WIDTH),
    .DEAD_TIME (50),
    .DEAD_W    (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_tri(input int t);
    bus.triangle = WIDTH'(t);
  endtask

  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {bus.hi_a, bus.lo_a, bus.hi_b, bus.lo_b, bus.busy, bus.fault};
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // hi/lo of a leg must never be on together
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      total++;
      assert (!(bus.hi_a & bus.lo_a) && !(bus.hi_b & bus.lo_b)) passed++;
      else $error("FAIL overlap observed=%b%b%b%b expected=no overlap",
                  bus.hi_a, bus.lo_a, bus.hi_b, bus.lo_b);
    end
  end

  initial begin
    reset     = 1'b1;
    bus.cw    = 1'b0;
    bus.ccw   = 1'b0;
    bus.lock  = 1'b0;
    bus.level = '0;
    set_tri(0);
    tick(2);
    chk("reset", 6'b000000);

    // cw, level 0, ramp from -1000: ARM until crossing
    reset    = 1'b0;
    bus.cw   = 1'b1;
    bus.lock = 1'b1;
    set_tri(-1000);
    tick(1);
    chk("arm_entry", 6'b000000);
    for (int t = -990; t < 0; t += 10) begin
      set_tri(t);
      tick(1);
      chk("arm_wait", 6'b000000);
    end
    set_tri(0);
    tick(1);
    chk("run_entry", 6'b000010);
    for (int k = 1; k < 50; k++) begin
      set_tri(10 * k);
      tick(1);
      chk("dead_cw_start", 6'b000010);
    end
    set_tri(500);
    tick(1);
    chk("cw_lo_a_hi_b_on", 6'b011010);

    // level 500: triangle 400 -> hi_a/lo_b after dead time
    bus.level = WIDTH'(500);
    set_tri(400);
    tick(1);
    chk("toggle_drop", 6'b000010);
    tick(49);
    chk("toggle_dead49", 6'b000010);
    tick(1);
    chk("hi_a_lo_b_on", 6'b100110);

    // triangle == level counts as not-greater
    set_tri(500);
    tick(1);
    chk("eq_drop", 6'b000010);
    tick(49);
    chk("eq_dead49", 6'b000010);
    tick(1);
    chk("eq_lo_a_hi_b_on", 6'b011010);

    // toggle away and back inside dead time restarts the count
    set_tri(400);
    tick(20);
    chk("restart_mid", 6'b000010);
    set_tri(500);
    tick(1);
    chk("restart_back", 6'b000010);
    tick(49);
    chk("restart_dead49", 6'b000010);
    tick(1);
    chk("restart_on", 6'b011010);

    // cw -> ccw in RUN: immediate off, re-arm, wait for crossing
    bus.cw  = 1'b0;
    bus.ccw = 1'b1;
    tick(1);
    chk("dir_switch_off", 6'b000000);
    tick(1);
    chk("dir_switch_arm", 6'b000000);
    bus.level = '0;
    set_tri(-10);
    tick(1);
    chk("ccw_no_cross", 6'b000000);
    set_tri(0);
    tick(1);
    chk("ccw_run_entry", 6'b000010);
    set_tri(10);
    tick(49);
    chk("ccw_dead49", 6'b000010);
    tick(1);
    chk("ccw_swapped_on", 6'b100110);

    // both directions high: fault, off; clearing ccw re-arms as cw
    bus.cw = 1'b1;
    tick(1);
    chk("fault_set", 6'b000001);
    bus.ccw = 1'b0;
    tick(1);
    chk("fault_clear_arm", 6'b000000);
    set_tri(-10);
    tick(1);
    chk("rearm_wait", 6'b000000);
    set_tri(0);
    tick(1);
    chk("rearm_run", 6'b000010);

    // one-cycle lock drop in RUN
    bus.lock = 1'b0;
    tick(1);
    chk("lock_drop", 6'b000000);
    bus.lock = 1'b1;
    set_tri(-10);
    tick(1);
    chk("lock_rearm", 6'b000000);

    // lock drop coincident with crossing in ARM: OFF wins
    bus.lock = 1'b0;
    set_tri(0);
    tick(1);
    chk("off_wins", 6'b000000);
    bus.lock = 1'b1;
    set_tri(-10);
    tick(1);
    chk("arm_again", 6'b000000);
    set_tri(0);
    tick(1);
    chk("run_again", 6'b000010);

    // reset mid dead time
    set_tri(10);
    tick(20);
    chk("mid_dead", 6'b000010);
    reset = 1'b1;
    tick(1);
    chk("reset_mid_run", 6'b000000);
    tick(1);
    chk("reset_hold", 6'b000000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
